accel_shot_detector: RTL

//  Consumes the ADXL362 X-axis sample stream (x_raw/x_valid) produced by the SPI reader.

---
 rtl/accel_shot_detector.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/accel_shot_detector.sv
// ============================================================================
//  Module      : accel_shot_detector
//  Description : X-axis moving-average filter followed by a swing/release FSM
//                that emits a one-cycle shot strobe with a 4-bit power value.
//                Optional build macro ACCEL_ABS_MODE_EN: detect swings in
//                either X direction using the magnitude of the filtered value.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module accel_shot_detector #(
    parameter int                 AVG_LOG2     = 2,
    parameter logic signed [11:0] ARM_TH       = 12'sd300,
    parameter logic signed [11:0] REL_TH       = 12'sd100,
    parameter int                 MIN_LEN      = 2,
    parameter int                 MAX_LEN      = 50,
    parameter int                 COOL_SAMPLES = 100,
    parameter int                 PWR_SHIFT    = 6
) (
    input  logic               iclk,
    input  logic               rst_n,
    input  logic [15:0]        x_raw,
    input  logic               x_valid,
    output logic signed [11:0] filt_x,
    output logic               filt_valid,
    output logic               shot_valid,
    output logic [3:0]         shot_power,
    output logic               busy
);

    localparam int c_PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_SW = 12 + AVG_LOG2;
    localparam int c_LW = $clog2(MAX_LEN + 1);
    localparam int c_CW = $clog2(COOL_SAMPLES + 1);

    localparam logic [c_LW-1:0] c_MIN_LEN = c_LW'(MIN_LEN);
    localparam logic [c_LW-1:0] c_MAX_LEN = c_LW'(MAX_LEN);
    localparam logic [c_CW-1:0] c_COOL    = c_CW'(COOL_SAMPLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWING = 2'd1,
        S_FIRE  = 2'd2,
        S_COOL  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Moving-average filter: stage 1 captures sample and evicted entry,
    // stage 2 updates the running sum and the filtered output.
    // ------------------------------------------------------------------
    logic signed [11:0]     r_ring [2**c_PW];
    logic [c_PW-1:0]        r_wptr;
    logic                   r_s1_valid;
    logic signed [11:0]     r_s1_x;
    logic signed [11:0]     r_s1_old;
    logic signed [c_SW-1:0] r_sum;

    logic signed [11:0]     w_x;
    logic [c_PW-1:0]        w_wptr_nxt;
    logic signed [c_SW-1:0] w_sum_nxt;
    logic signed [c_SW-1:0] w_sum_shr;

    assign w_x        = signed'(x_raw[11:0]);
    // A depth-1 buffer keeps its pointer parked on entry 0.
    assign w_wptr_nxt = (AVG_LOG2 == 0) ? '0 : r_wptr + 1'b1;
    assign w_sum_nxt  = r_sum + c_SW'(r_s1_x) - c_SW'(r_s1_old);
    assign w_sum_shr  = w_sum_nxt >>> AVG_LOG2;

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**c_PW; i++) begin
                r_ring[i] <= '0;
            end
            r_wptr     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_old   <= '0;
            r_sum      <= '0;
            filt_x     <= '0;
            filt_valid <= 1'b0;
        end else begin
            r_s1_valid <= x_valid;
            filt_valid <= r_s1_valid;
            if (x_valid) begin
                r_s1_x         <= w_x;
                r_s1_old       <= r_ring[r_wptr];
                r_ring[r_wptr] <= w_x;
                r_wptr         <= w_wptr_nxt;
            end
            if (r_s1_valid) begin
                r_sum  <= w_sum_nxt;
                filt_x <= w_sum_shr[11:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Detection metric
    // ------------------------------------------------------------------
    logic signed [11:0] w_m;

    always_comb begin
        w_m = filt_x;
`ifdef ACCEL_ABS_MODE_EN
        if (filt_x == -12'sd2048) begin
            w_m = 12'sd2047;
        end else if (filt_x[11]) begin
            w_m = -filt_x;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Swing / release FSM
    // ------------------------------------------------------------------
    state_t             r_state, w_state_nxt;
    logic signed [11:0] r_peak, w_peak_nxt;
    logic [c_LW-1:0]    r_len, w_len_nxt, w_len_inc;
    logic [c_CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]         w_pwr_nxt;

    logic signed [12:0] w_diff;
    logic [12:0]        w_diff_sh;
    logic [3:0]         w_pwr;

    // Peak never drops below ARM_TH, so the 13-bit difference is non-negative.
    assign w_diff    = {r_peak[11], r_peak} - {ARM_TH[11], ARM_TH};
    assign w_diff_sh = unsigned'(w_diff) >> PWR_SHIFT;
    assign w_pwr     = (|w_diff_sh[12:4]) ? 4'd15 : w_diff_sh[3:0];
    assign w_len_inc = r_len + 1'b1;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_peak     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            shot_power <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_peak     <= w_peak_nxt;
            r_len      <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            shot_power <= w_pwr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_peak_nxt  = r_peak;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_pwr_nxt   = shot_power;
        case (r_state)
            S_IDLE: begin
                if (filt_valid && (w_m >= ARM_TH)) begin
                    w_state_nxt = S_SWING;
                    w_peak_nxt  = w_m;
                    w_len_nxt   = c_LW'(1);
                end
            end
            S_SWING: begin
                if (filt_valid) begin
                    if (w_m < REL_TH) begin
                        if (r_len >= c_MIN_LEN) begin
                            // Power is latched here so it is valid alongside the strobe.
                            w_state_nxt = S_FIRE;
                            w_pwr_nxt   = w_pwr;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        if (w_m > r_peak) begin
                            w_peak_nxt = w_m;
                        end
                        w_len_nxt = w_len_inc;
                        if (w_len_inc == c_MAX_LEN) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            S_FIRE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_COOL;
            end
            S_COOL: begin
                if (filt_valid) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_COOL) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign shot_valid = (r_state == S_FIRE);
    assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire
